// File: rtl/cpu_oci_dct_packer_if.sv
// Symbol-in / frame-out bus of the DCT trace packer.
// The producer/consumer side uses master; the packer uses slave.
interface cpu_oci_dct_packer_if;
  logic        sym_valid;
  logic [1:0]  sym;
  logic        sym_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  frame_cnt;

  modport master (
    output sym_valid, sym, flush, out_ready,
    input  sym_ready, out_valid, dct_buffer, dct_count, frame_cnt
  );

  modport slave (
    input  sym_valid, sym, flush, out_ready,
    output sym_ready, out_valid, dct_buffer, dct_count, frame_cnt
  );
endinterface

// File: rtl/cpu_oci_dct_packer.sv
// Packs 2-bit trace symbols into frames of up to 15 symbols (newest in [1:0]).
// Frames are handed off on a full accumulator or on a flush request.
module cpu_oci_dct_packer (
  input  logic                         clk,
  input  logic                         reset_n,
  cpu_oci_dct_packer_if.slave          bus
);
  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL} state_t;

  state_t      state_reg;
  logic [29:0] acc_reg;
  logic [3:0]  acc_cnt_reg;
  logic        flush_pend_reg;
  logic        out_valid_reg;
  logic [29:0] dct_buffer_reg;
  logic [3:0]  dct_count_reg;
  logic [7:0]  frame_cnt_reg;

  logic        sym_ready;
  logic        accept;
  logic [29:0] acc_next;
  logic [3:0]  acc_cnt_next;
  logic        flush_any;
  logic        xfer_req;
  logic        out_free;
  logic        xfer;

  // Ready depends only on registered state so it never loops back to sym_valid.
  assign sym_ready = (acc_cnt_reg != 4'd15);

  always_comb begin
    accept       = bus.sym_valid && sym_ready;
    acc_next     = acc_reg;
    acc_cnt_next = acc_cnt_reg;
    if (accept) begin
      acc_next     = {acc_reg[27:0], bus.sym};
      acc_cnt_next = acc_cnt_reg + 4'd1;
    end
    flush_any = bus.flush || flush_pend_reg;
    xfer_req  = (acc_cnt_next == 4'd15) || (flush_any && (acc_cnt_next != 4'd0));
    out_free  = !out_valid_reg || bus.out_ready;
    xfer      = xfer_req && out_free;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_EMPTY;
      acc_reg        <= '0;
      acc_cnt_reg    <= '0;
      flush_pend_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      dct_buffer_reg <= '0;
      dct_count_reg  <= '0;
      frame_cnt_reg  <= '0;
    end else begin
      if (xfer) begin
        dct_buffer_reg <= acc_next;
        dct_count_reg  <= acc_cnt_next;
        out_valid_reg  <= 1'b1;
        acc_reg        <= '0;
        acc_cnt_reg    <= '0;
        flush_pend_reg <= 1'b0;
        frame_cnt_reg  <= frame_cnt_reg + 8'd1;
      end else begin
        acc_reg        <= acc_next;
        acc_cnt_reg    <= acc_cnt_next;
        // A blocked flush is remembered; a flush of nothing is dropped.
        flush_pend_reg <= flush_any && (acc_cnt_next != 4'd0);
        if (bus.out_ready)
          out_valid_reg <= 1'b0;
      end

      case (state_reg)
        S_EMPTY: if (accept && !xfer) state_reg <= S_FILL;
        S_FILL: begin
          if (xfer)                           state_reg <= S_EMPTY;
          else if (acc_cnt_next == 4'd15)     state_reg <= S_FULL;
        end
        S_FULL:  if (xfer) state_reg <= S_EMPTY;
        default: state_reg <= S_EMPTY;
      endcase
    end
  end

  assign bus.sym_ready  = sym_ready;
  assign bus.out_valid  = out_valid_reg;
  assign bus.dct_buffer = dct_buffer_reg;
  assign bus.dct_count  = dct_count_reg;
  assign bus.frame_cnt  = frame_cnt_reg;
endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Directed bench for cpu_oci_dct_packer: full frames, flushes, backpressure,
// asynchronous reset and frame counter wrap.
module tb_cpu_oci_dct_packer;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   exp_frames;

  cpu_oci_dct_packer_if bus ();

  cpu_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end else begin
      $display("check %s: %0h ok", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sym_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym       = s;
      step();
    end
    bus.sym_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [3:0] cnt, input logic [29:0] buf_v);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_count"}, {28'd0, bus.dct_count}, {28'd0, cnt});
    check({tag, "_buffer"}, {2'd0, bus.dct_buffer}, {2'd0, buf_v});
    check({tag, "_frames"}, {24'd0, bus.frame_cnt}, exp_frames[7:0]);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    exp_frames    = 0;
    reset_n       = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym       = 2'b00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.sym_ready}, 32'd1);
    check("rst_frames", {24'd0, bus.frame_cnt}, 32'd0);
    check("rst_buffer", {2'd0, bus.dct_buffer}, 32'd0);
    reset_n = 1'b1;

    // Full frame of 15 x 01
    send(2'b01, 15);
    exp_frames++;
    check_frame("full", 4'd15, 30'h15555555);
    check("full_ready", {31'd0, bus.sym_ready}, 32'd1);
    step();
    check("full_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    check("full_hold_buffer", {2'd0, bus.dct_buffer}, 32'h15555555);

    // Flush of a 2-symbol partial frame
    send(2'b11, 1);
    send(2'b10, 1);
    check("partial_no_frame", {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    exp_frames++;
    check_frame("flush2", 4'd2, 30'h0000000E);
    step();

    // Flush with nothing accumulated, then accept together with flush
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("empty_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    check("empty_flush_nopend", {31'd0, bus.out_valid}, 32'd0);
    check("empty_flush_frames", {24'd0, bus.frame_cnt}, exp_frames);
    bus.flush = 1'b1;
    send(2'b10, 1);
    bus.flush = 1'b0;
    exp_frames++;
    check_frame("acc_flush", 4'd1, 30'h2);
    step();

    // Backpressure: one frame held, second frame stalls at 15 symbols
    bus.out_ready = 1'b0;
    send(2'b10, 15);
    exp_frames++;
    check_frame("bp_first", 4'd15, 30'h2AAAAAAA);
    send(2'b11, 15);
    check("bp_stall_ready", {31'd0, bus.sym_ready}, 32'd0);
    check("bp_hold_buffer", {2'd0, bus.dct_buffer}, 32'h2AAAAAAA);
    bus.sym_valid = 1'b1;
    bus.sym       = 2'b01;
    step();
    step();
    check("bp_16th_blocked", {31'd0, bus.sym_ready}, 32'd0);
    check("bp_frames_held", {24'd0, bus.frame_cnt}, exp_frames);
    bus.sym_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    exp_frames++;
    check_frame("bp_second", 4'd15, 30'h3FFFFFFF);
    check("bp_ready_back", {31'd0, bus.sym_ready}, 32'd1);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("bp_16th_dropped", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back frames at full throughput
    send(2'b01, 15);
    exp_frames++;
    check("b2b_first_valid", {31'd0, bus.out_valid}, 32'd1);
    send(2'b11, 15);
    exp_frames++;
    check_frame("b2b_second", 4'd15, 30'h3FFFFFFF);
    step();

    // Reset mid-operation with a frame held and a pending flush
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    send(2'b01, 1);
    send(2'b10, 7);
    bus.flush = 1'b0;
    check("mid_valid_before", {31'd0, bus.out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.sym_ready}, 32'd1);
    check("mid_rst_frames", {24'd0, bus.frame_cnt}, 32'd0);
    check("mid_rst_buffer", {2'd0, bus.dct_buffer}, 32'd0);
    check("mid_rst_count", {28'd0, bus.dct_count}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    reset_n = 1'b1;
    exp_frames = 0;
    step();
    step();
    step();
    check("mid_no_frame", {31'd0, bus.out_valid}, 32'd0);
    check("mid_no_frames", {24'd0, bus.frame_cnt}, 32'd0);

    // Frame counter wrap: 256 one-symbol flushed frames, back to back
    bus.flush = 1'b1;
    send(2'b11, 255);
    check("wrap_255", {24'd0, bus.frame_cnt}, 32'd255);
    send(2'b11, 1);
    bus.flush = 1'b0;
    check("wrap_0", {24'd0, bus.frame_cnt}, 32'd0);
    check("wrap_count", {28'd0, bus.dct_count}, 32'd1);
    check("wrap_buffer", {2'd0, bus.dct_buffer}, 32'd3);

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cpu_oci_dct_packer.md
CPU_OCI_DCT_PACKER -- requirements
Module: cpu_oci_dct_packer

Interface
REQ-001 SHALL have no parameters: buffer width 30 bits (15 two-bit symbols) and count width 4 bits are fixed.
REQ-002 SHALL use this port list, one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sym_valid  in  1  trace symbol offered.
- sym  in  2  trace symbol value.
- sym_ready  out  1  symbol accepted this cycle when high with sym_valid.
- flush  in  1  single-cycle pulse: emit partial buffer.
- out_ready  in  1  downstream accepts frame.
- out_valid  out  1  frame present on dct_buffer/dct_count.
- dct_buffer  out  30  packed symbols, newest in [1:0].
- dct_count  out  4  number of valid symbols in dct_buffer, 1..15.
- frame_cnt  out  8  frames handed off, wraps 255->0.

Function
REQ-003 SHALL hold an accumulator (acc[29:0], acc_cnt[3:0]) and one output register (dct_buffer, dct_count, out_valid).
REQ-004 SHALL accept a symbol on a rising edge when sym_valid && sym_ready: acc <= {acc[27:0], sym}, acc_cnt <= acc_cnt+1.
REQ-005 SHALL keep unused upper bits of acc and dct_buffer zero; valid symbols occupy bits [2*count-1:0], oldest highest.
REQ-006 SHALL drive sym_ready = (acc_cnt != 15), combinationally from registered state only.
REQ-007 SHALL latch flush into flush_pend; flush_pend clears when a transfer occurs or when acc_cnt_next == 0 at the time it is evaluated.
REQ-008 SHALL compute acc_cnt_next and acc_next from the current state plus any acceptance in the same cycle.
REQ-009 SHALL request transfer when acc_cnt_next == 15, or when (flush || flush_pend) && acc_cnt_next > 0.
REQ-010 SHALL perform transfer only when the output register is free (!out_valid || out_ready): dct_buffer <= acc_next, dct_count <= acc_cnt_next, out_valid <= 1, acc <= 0, acc_cnt <= 0, frame_cnt += 1.
REQ-011 SHALL, when transfer is requested but the output register is not free, keep acc_next/acc_cnt_next and retain the request; at 15 symbols this stalls input via sym_ready = 0.
REQ-012 SHALL clear out_valid on out_ready when no transfer occurs in the same cycle; dct_buffer/dct_count hold their last values while out_valid = 0.
REQ-013 SHALL keep dct_buffer/dct_count stable while out_valid && !out_ready.
REQ-014 SHALL implement accumulator states: EMPTY (acc_cnt = 0), FILL (1..14), FULL (15, blocked); EMPTY->FILL on accept; FILL->FULL on the 15th accept with output busy; FILL/FULL->EMPTY on transfer.
REQ-015 SHALL treat flush with acc_cnt_next = 0 as a no-op: no frame and no pending flag.
REQ-016 SHALL, on simultaneous accept + flush, include the accepted symbol in the flushed frame.
REQ-017 SHALL support back-to-back frames at full throughput: a 15th accept with out_valid && out_ready transfers in the same edge with no stall cycle.

Reset
REQ-018 SHALL, on reset_n low, asynchronously clear acc, acc_cnt, flush_pend, out_valid, dct_buffer, dct_count and frame_cnt to 0; sym_ready = 1 during and after reset.
REQ-019 SHALL discard any partial accumulator and any unacknowledged frame on reset mid-operation, with no frame emitted after release.
REQ-020 SHALL release reset without a glitch on out_valid; the first accept is allowed on the first rising edge after reset_n goes high.

Verification
REQ-021 Full frame: 15 accepts of sym = 2'b01 with out_ready = 1 -> next cycle out_valid = 1, dct_count = 15, dct_buffer = 30'h15555555, frame_cnt = 1.
REQ-022 Flush partial: accept 2'b11 then 2'b10, then a flush pulse -> dct_count = 2, dct_buffer = 30'h0000000E.
REQ-023 Backpressure: out_ready = 0 with one frame held, then 15 more accepts -> sym_ready = 0 and the 16th symbol is not accepted; raising out_ready -> the second frame loads on that edge and sym_ready returns to 1.
REQ-024 Empty flush and accept + flush: flush with acc_cnt = 0 -> out_valid stays 0; accept 2'b10 together with flush -> dct_count = 1, dct_buffer = 30'h2.
REQ-025 Reset mid-operation: 7 symbols accumulated and a frame pending, assert reset_n = 0 asynchronously -> all outputs 0 immediately and sym_ready = 1; after release no frame appears.
REQ-026 Wrap: 256 one-symbol flushed frames -> frame_cnt returns to 0.
